// File: rtl/i2c_slv_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_slv_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RD_ACK,
      ST_IDLE_WAIT,
      ST_GCALL,
      ST_GCALL_ACK
   } state_e;

   localparam logic [6:0] GCALL_ADDR  = 7'h00;
   localparam logic [7:0] GCALL_RESET = 8'h06;

endpackage

// File: rtl/i2c_slv_filter.sv
// SCL/SDA conditioning: 2-flop synchronizer, FILTER_LEN-sample glitch filter,
// and registered SCL edge / START / STOP pulses aligned with the filtered levels.
module i2c_slv_filter #(
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [1:0]    scl_sync;
   logic [1:0]    sda_sync;
   logic          scl;
   logic [CW-1:0] scl_cnt;
   logic [CW-1:0] sda_cnt;
   logic          scl_acc_c;
   logic          sda_acc_c;

   // a new level is accepted on the FILTER_LEN-th consecutive differing sample
   assign scl_acc_c = (scl_sync[1] != scl) && (scl_cnt == CW'(FILTER_LEN - 1));
   assign sda_acc_c = (sda_sync[1] != sda) && (sda_cnt == CW'(FILTER_LEN - 1));

   // metastability synchronizers, idle-high after reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
      end else begin
         scl_sync <= {scl_sync[0], scl_i};
         sda_sync <= {sda_sync[0], sda_i};
      end
   end

   // glitch filter counters, filtered levels and event pulses
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scl_cnt   <= '0;
         sda_cnt   <= '0;
         scl       <= 1'b1;
         sda       <= 1'b1;
         scl_rise  <= 1'b0;
         scl_fall  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
      end else begin
         if ((scl_sync[1] == scl) || scl_acc_c) scl_cnt <= '0;
         else                                   scl_cnt <= scl_cnt + CW'(1);
         if ((sda_sync[1] == sda) || sda_acc_c) sda_cnt <= '0;
         else                                   sda_cnt <= sda_cnt + CW'(1);
         if (scl_acc_c) scl <= scl_sync[1];
         if (sda_acc_c) sda <= sda_sync[1];
         scl_rise  <= scl_acc_c & scl_sync[1];
         scl_fall  <= scl_acc_c & ~scl_sync[1];
         start_det <= sda_acc_c & ~sda_sync[1] & scl;
         stop_det  <= sda_acc_c & sda_sync[1] & scl;
      end
   end

endmodule

// File: rtl/i2c_regfile_slv.sv
// I2C target exposing NUM_REGS byte registers behind a register pointer.
// Optional general-call reset is enabled with macro I2C_SLV_GCALL_EN.
module i2c_regfile_slv
   import i2c_slv_pkg::*;
#(
   parameter logic [6:0]  I2C_ADDR   = 7'h10,
   parameter int unsigned NUM_REGS   = 4,
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        scl_i,
   input  logic                        sda_i,
   output logic                        sda_oe_o,
   output logic [NUM_REGS*8-1:0]       reg_q_o,
   output logic                        wr_stb_o,
   output logic [$clog2(NUM_REGS)-1:0] wr_idx_o,
   output logic                        busy_o
);

   localparam int unsigned IW = $clog2(NUM_REGS);
   localparam int unsigned RW = NUM_REGS * 8;
`ifdef I2C_SLV_GCALL_EN
   localparam bit GCALL_EN = 1'b1;
`else
   localparam bit GCALL_EN = 1'b0;
`endif

   state_e          state, state_nxt;
   logic [7:0]      sr, sr_nxt;
   logic [3:0]      cnt, cnt_nxt;
   logic [IW-1:0]   ptr, ptr_nxt;
   logic            sda_oe_nxt, busy_nxt, wr_stb_nxt;
   logic [IW-1:0]   wr_idx_nxt;
   logic [RW-1:0]   reg_nxt;

   logic sda, scl_rise, scl_fall, start_det, stop_det;
   logic byte_done_c, addr_hit_c, gcall_hit_c, rx_state_c;
   logic [7:0] rd_byte_c;

   i2c_slv_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .sda       (sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   assign byte_done_c = scl_fall && (cnt == 4'd8);
   assign addr_hit_c  = (sr[7:1] == I2C_ADDR);
   assign gcall_hit_c = GCALL_EN && (sr == {GCALL_ADDR, 1'b0});
   assign rx_state_c  = (state == ST_ADDR) || (state == ST_PTR) ||
                        (state == ST_WDATA) || (state == ST_GCALL);
   assign rd_byte_c   = reg_q_o[{ptr, 3'b000} +: 8];

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // next-state logic; bus conditions override every state
   always_comb begin
      state_nxt = state;
      if (start_det) state_nxt = ST_ADDR;
      else if (stop_det) state_nxt = ST_IDLE;
      else begin
         case (state)
            ST_ADDR:      if (byte_done_c)
                             state_nxt = (addr_hit_c || gcall_hit_c) ? ST_ADDR_ACK : ST_IDLE;
            ST_ADDR_ACK:  if (scl_fall)
                             state_nxt = gcall_hit_c ? ST_GCALL : (sr[0] ? ST_RDATA : ST_PTR);
            ST_PTR:       if (byte_done_c) state_nxt = ST_PTR_ACK;
            ST_PTR_ACK:   if (scl_fall)    state_nxt = ST_WDATA;
            ST_WDATA:     if (byte_done_c) state_nxt = ST_WDATA_ACK;
            ST_WDATA_ACK: if (scl_fall)    state_nxt = ST_WDATA;
            ST_RDATA:     if (scl_fall && (cnt == 4'd7)) state_nxt = ST_RD_ACK;
            ST_RD_ACK:    if (scl_fall)    state_nxt = sr[0] ? ST_IDLE_WAIT : ST_RDATA;
            ST_GCALL:     if (byte_done_c)
                             state_nxt = (sr == GCALL_RESET) ? ST_GCALL_ACK : ST_IDLE_WAIT;
            ST_GCALL_ACK: if (scl_fall)    state_nxt = ST_IDLE_WAIT;
            default:      ;
         endcase
      end
   end

   // datapath and output next values
   always_comb begin
      sda_oe_nxt = sda_oe_o;
      busy_nxt   = busy_o;
      wr_stb_nxt = 1'b0;
      wr_idx_nxt = wr_idx_o;
      reg_nxt    = reg_q_o;
      ptr_nxt    = ptr;
      sr_nxt     = sr;
      cnt_nxt    = cnt;
      if (start_det) begin
         sda_oe_nxt = 1'b0;
         cnt_nxt    = 4'd0;
      end else if (stop_det) begin
         sda_oe_nxt = 1'b0;
         cnt_nxt    = 4'd0;
         busy_nxt   = 1'b0;
      end else begin
         if (rx_state_c && scl_rise && (cnt != 4'd8)) begin
            sr_nxt  = {sr[6:0], sda};
            cnt_nxt = cnt + 4'd1;
         end
         if (rx_state_c && byte_done_c) cnt_nxt = 4'd0;
         case (state)
            ST_ADDR: if (byte_done_c) begin
               if (addr_hit_c || gcall_hit_c) begin
                  sda_oe_nxt = 1'b1;
                  busy_nxt   = 1'b1;
               end else begin
                  busy_nxt   = 1'b0;
               end
            end
            ST_PTR: if (byte_done_c) begin
               sda_oe_nxt = 1'b1;
               ptr_nxt    = sr[IW-1:0];
            end
            ST_WDATA: if (byte_done_c) begin
               sda_oe_nxt = 1'b1;
               reg_nxt[{ptr, 3'b000} +: 8] = sr;
               wr_stb_nxt = 1'b1;
               wr_idx_nxt = ptr;
               ptr_nxt    = ptr + IW'(1);
            end
            ST_GCALL: if (byte_done_c && (sr == GCALL_RESET)) begin
               sda_oe_nxt = 1'b1;
               reg_nxt    = '0;
               ptr_nxt    = '0;
            end
            ST_ADDR_ACK: if (scl_fall) begin
               sda_oe_nxt = 1'b0;
               cnt_nxt    = 4'd0;
               if (!gcall_hit_c && sr[0]) begin
                  sr_nxt     = rd_byte_c;
                  sda_oe_nxt = ~rd_byte_c[7];
               end
            end
            ST_PTR_ACK, ST_WDATA_ACK, ST_GCALL_ACK: if (scl_fall) begin
               sda_oe_nxt = 1'b0;
               cnt_nxt    = 4'd0;
            end
            ST_RDATA: if (scl_fall) begin
               if (cnt == 4'd7) begin
                  sda_oe_nxt = 1'b0;
                  cnt_nxt    = 4'd0;
                  ptr_nxt    = ptr + IW'(1);
               end else begin
                  sr_nxt     = {sr[6:0], 1'b0};
                  sda_oe_nxt = ~sr[6];
                  cnt_nxt    = cnt + 4'd1;
               end
            end
            ST_RD_ACK: begin
               if (scl_rise) sr_nxt = {sr[6:0], sda};
               if (scl_fall) begin
                  cnt_nxt = 4'd0;
                  if (!sr[0]) begin
                     sr_nxt     = rd_byte_c;
                     sda_oe_nxt = ~rd_byte_c[7];
                  end else begin
                     sda_oe_nxt = 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // datapath and output registers; reset releases SDA asynchronously
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sda_oe_o <= 1'b0;
         busy_o   <= 1'b0;
         wr_stb_o <= 1'b0;
         wr_idx_o <= '0;
         reg_q_o  <= '0;
         ptr      <= '0;
         sr       <= '0;
         cnt      <= '0;
      end else begin
         sda_oe_o <= sda_oe_nxt;
         busy_o   <= busy_nxt;
         wr_stb_o <= wr_stb_nxt;
         wr_idx_o <= wr_idx_nxt;
         reg_q_o  <= reg_nxt;
         ptr      <= ptr_nxt;
         sr       <= sr_nxt;
         cnt      <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_i2c_regfile_slv.sv
// Directed bench for i2c_regfile_slv: bit-banged I2C master on a wired-AND SDA,
// scoreboards for register writes and read-back data.
module tb_i2c_regfile_slv;

   localparam int unsigned Q = 12;   // quarter SCL period in clk cycles

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_drv = 1'b1;
   logic       sda_drv = 1'b1;
   logic       sda_bus;
   logic       sda_oe;
   logic [31:0] reg_q;
   logic       wr_stb;
   logic [1:0] wr_idx;
   logic       busy;

   int checks = 0;
   int failures = 0;

   logic [7:0]  mdl [4];
   logic [9:0]  wr_q [$];   // {idx, data}
   logic [7:0]  rd_q [$];

   assign sda_bus = sda_drv & ~sda_oe;

   i2c_regfile_slv #(.I2C_ADDR(7'h10), .NUM_REGS(4), .FILTER_LEN(3)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .scl_i    (scl_drv),
      .sda_i    (sda_bus),
      .sda_oe_o (sda_oe),
      .reg_q_o  (reg_q),
      .wr_stb_o (wr_stb),
      .wr_idx_o (wr_idx),
      .busy_o   (busy)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mdl_vec();
      return {mdl[3], mdl[2], mdl[1], mdl[0]};
   endfunction

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_drv = 1'b1; wait_q();
      scl_drv = 1'b1; wait_q();
      sda_drv = 1'b0; wait_q();
      scl_drv = 1'b0; wait_q();
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; wait_q();
      scl_drv = 1'b1; wait_q();
      sda_drv = 1'b1; wait_q();
   endtask

   task automatic bit_xfer(input logic b, output logic r);
      sda_drv = b;    wait_q();
      scl_drv = 1'b1; wait_q();
      r = sda_bus;    wait_q();
      scl_drv = 1'b0; wait_q();
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
      bit_xfer(1'b1, ack);
   endtask

   task automatic read_byte(input logic master_ack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, r);
         d[i] = r;
      end
      bit_xfer(~master_ack, r);
   endtask

   // write scoreboard: every strobe must match the next queued write
   always @(negedge clk) begin
      if (rst_n && wr_stb) begin
         if (wr_q.size() == 0) begin
            check("wr_stb_unexpected", 32'd1, 32'd0);
         end else begin
            logic [9:0] e;
            e = wr_q.pop_front();
            check("wr_idx", 32'(wr_idx), 32'(e[9:8]));
            check("wr_data", 32'(reg_q[{wr_idx, 3'b000} +: 8]), 32'(e[7:0]));
         end
      end
   end

   task automatic do_write(input logic [1:0] idx, input logic [7:0] d);
      logic ack;
      wr_q.push_back({idx, d});
      mdl[idx] = d;
      write_byte(d, ack);
      check("wdata_ack", 32'(ack), 32'd0);
   endtask

   task automatic do_read(input logic master_ack, input logic [1:0] idx);
      logic [7:0] d, e;
      rd_q.push_back(mdl[idx]);
      read_byte(master_ack, d);
      e = rd_q.pop_front();
      check("rdata", 32'(d), 32'(e));
   endtask

   initial begin
      logic       ack;
      logic       r;
      logic [3:0] bits;

      for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
      repeat (5) @(negedge clk);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_reg_q", reg_q, 32'd0);
      check("rst_wr_stb", 32'(wr_stb), 32'd0);
      check("rst_wr_idx", 32'(wr_idx), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // write ptr 1, two data bytes
      i2c_start();
      write_byte(8'h20, ack); check("addr_w_ack", 32'(ack), 32'd0);
      check("busy_after_addr", 32'(busy), 32'd1);
      write_byte(8'h01, ack); check("ptr_ack", 32'(ack), 32'd0);
      do_write(2'd1, 8'hA5);
      do_write(2'd2, 8'h3C);
      i2c_stop();
      repeat (10) @(negedge clk);
      check("regs_after_write", reg_q, mdl_vec());
      check("busy_after_stop", 32'(busy), 32'd0);

      // write wrapping from reg3 to reg0
      i2c_start();
      write_byte(8'h20, ack); check("addr_w_ack2", 32'(ack), 32'd0);
      write_byte(8'h03, ack); check("ptr_ack2", 32'(ack), 32'd0);
      do_write(2'd3, 8'h5A);
      do_write(2'd0, 8'hC3);
      i2c_stop();
      repeat (10) @(negedge clk);
      check("regs_after_wrap_write", reg_q, mdl_vec());

      // pointer 3, repeated START, read reg3 then reg0
      i2c_start();
      write_byte(8'h20, ack); check("addr_w_ack3", 32'(ack), 32'd0);
      write_byte(8'h03, ack); check("ptr_ack3", 32'(ack), 32'd0);
      i2c_start();
      write_byte(8'h21, ack); check("addr_r_ack", 32'(ack), 32'd0);
      do_read(1'b1, 2'd3);
      do_read(1'b0, 2'd0);
      check("sda_released_after_nack", 32'(sda_oe), 32'd0);
      check("busy_after_nack", 32'(busy), 32'd1);
      i2c_stop();

      // pointer persists across transactions: next read is reg1
      i2c_start();
      write_byte(8'h21, ack); check("addr_r_ack2", 32'(ack), 32'd0);
      do_read(1'b0, 2'd1);
      i2c_stop();

      // wrong address: no ACK, not busy
      i2c_start();
      write_byte(8'h22, ack); check("wrong_addr_nack", 32'(ack), 32'd1);
      check("wrong_addr_busy", 32'(busy), 32'd0);
      i2c_stop();
      repeat (10) @(negedge clk);
      check("regs_after_wrong_addr", reg_q, mdl_vec());

      // STOP after 4 data bits discards the byte
      i2c_start();
      write_byte(8'h20, ack); check("addr_w_ack4", 32'(ack), 32'd0);
      write_byte(8'h01, ack); check("ptr_ack4", 32'(ack), 32'd0);
      for (int i = 0; i < 4; i++) bit_xfer(1'b0, r);
      i2c_stop();
      repeat (10) @(negedge clk);
      check("partial_sda_oe", 32'(sda_oe), 32'd0);
      check("partial_busy", 32'(busy), 32'd0);
      check("partial_regs", reg_q, mdl_vec());

      // reset during read of reg1 (0xA5), bit 3 is 0 so SDA is pulled
      i2c_start();
      write_byte(8'h21, ack); check("addr_r_ack3", 32'(ack), 32'd0);
      for (int i = 3; i >= 0; i--) begin
         bit_xfer(1'b1, r);
         bits[i] = r;
      end
      check("read_upper_nibble", 32'(bits), 32'hA);
      check("sda_oe_bit3", 32'(sda_oe), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_sda_oe", 32'(sda_oe), 32'd0);
      check("async_rst_reg_q", reg_q, 32'd0);
      for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // normal transaction after reset
      i2c_start();
      write_byte(8'h20, ack); check("post_rst_addr_ack", 32'(ack), 32'd0);
      write_byte(8'h00, ack); check("post_rst_ptr_ack", 32'(ack), 32'd0);
      do_write(2'd0, 8'h77);
      i2c_start();
      write_byte(8'h20, ack); check("post_rst_addr_ack2", 32'(ack), 32'd0);
      write_byte(8'h00, ack); check("post_rst_ptr_ack2", 32'(ack), 32'd0);
      i2c_start();
      write_byte(8'h21, ack); check("post_rst_addr_r_ack", 32'(ack), 32'd0);
      do_read(1'b0, 2'd0);
      i2c_stop();
      repeat (10) @(negedge clk);
      check("post_rst_regs", reg_q, mdl_vec());

      // general call
      i2c_start();
`ifdef I2C_SLV_GCALL_EN
      write_byte(8'h00, ack); check("gcall_addr_ack", 32'(ack), 32'd0);
      write_byte(8'h06, ack); check("gcall_reset_ack", 32'(ack), 32'd0);
      for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
`else
      write_byte(8'h00, ack); check("gcall_addr_nack", 32'(ack), 32'd1);
      check("gcall_busy", 32'(busy), 32'd0);
`endif
      i2c_stop();
      repeat (10) @(negedge clk);
      check("gcall_regs", reg_q, mdl_vec());

      check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
